spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 141 ++++++++++++++
 tb/tb_spi_slave.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_slave                                                  |
// | Description : SPI slave front-end for a small memory. Receives 10-bit    |
// |               frames {cmd[1:0], payload[7:0]} MSB first, hands them to   |
// |               memory on rx_data/rx_valid, and shifts memory read data    |
// |               back out on MISO after a read-data frame.                  |
// | Ports       : clk       system clock, doubles as the SPI serial clock    |
// |               rst_n     synchronous active-low reset                     |
// |               SS_n      slave select, active-low (high = idle / abort)   |
// |               MOSI      serial data in, MSB first                        |
// |               MISO      serial read data out, MSB first, registered      |
// |               rx_data   last complete received frame                     |
// |               rx_valid  one-cycle strobe marking a new rx_data           |
// |               tx_data   read data from memory                            |
// |               tx_valid  tx_data valid strobe                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;

  // bit_cnt counts payload bits b8..b0 in a data state; 9 means the frame
  // is complete and further MOSI bits are ignored.
  logic [3:0] bit_cnt;
  logic [8:0] rx_shift;
  logic       rd_addr_flag;
  logic [7:0] tx_shift;
  // tx_cnt: 0 = waiting for tx_valid, 8..1 = transmit in progress.
  logic [3:0] tx_cnt;
  // tx_done blocks a second load once the read byte has been sent.
  logic       tx_done;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!SS_n) state_next = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)              state_next = IDLE;
        else if (!MOSI)        state_next = WRITE;
        else if (rd_addr_flag) state_next = READ_DATA;
        else                   state_next = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Receive / transmit datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt      <= 4'd0;
      rx_shift     <= 9'd0;
      rx_data      <= 10'd0;
      rx_valid     <= 1'b0;
      rd_addr_flag <= 1'b0;
      tx_shift     <= 8'd0;
      tx_cnt       <= 4'd0;
      tx_done      <= 1'b0;
      MISO         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n || (state == IDLE)) begin
        // Idle or abort: drop any partial frame and any transmit. The
        // read-address flag deliberately survives an abort.
        bit_cnt  <= 4'd0;
        rx_shift <= 9'd0;
        tx_shift <= 8'd0;
        tx_cnt   <= 4'd0;
        tx_done  <= 1'b0;
        MISO     <= 1'b0;
      end else if (state == CHK_CMD) begin
        bit_cnt  <= 4'd0;
        rx_shift <= {8'd0, MOSI};
      end else if (bit_cnt != 4'd9) begin
        rx_shift <= {rx_shift[7:0], MOSI};
        bit_cnt  <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd8) begin
          // b0 arrives now: publish the whole frame unmodified.
          rx_data  <= {rx_shift, MOSI};
          rx_valid <= 1'b1;
          if (state == READ_ADD) rd_addr_flag <= 1'b1;
        end
      end else if ((state == READ_DATA) && !tx_done) begin
        if (tx_cnt == 4'd0) begin
          if (tx_valid) begin
            // MSB goes straight to the MISO register so it appears on
            // the cycle right after the load.
            MISO     <= tx_data[7];
            tx_shift <= {tx_data[6:0], 1'b0};
            tx_cnt   <= 4'd8;
          end
        end else if (tx_cnt == 4'd1) begin
          MISO         <= 1'b0;
          tx_cnt       <= 4'd0;
          tx_done      <= 1'b1;
          rd_addr_flag <= 1'b0;
        end else begin
          MISO     <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
          tx_cnt   <= tx_cnt - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spi_slave                                               |
// | Description : Directed self-checking bench for spi_slave. Inputs change  |
// |               1ns after each rising edge; outputs are sampled there too. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int vectors = 0;
  int errors  = 0;

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full frame: SS_n low, one cycle for IDLE->CHK_CMD, then b9..b0.
  task automatic send_frame(input logic [9:0] f);
    SS_n = 1'b0;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = f[i];
      tick();
      check("miso_during_rx", {31'd0, MISO}, 32'd0);
      if (i > 0) check("rx_valid_early", {31'd0, rx_valid}, 32'd0);
    end
    check("rx_valid_pulse", {31'd0, rx_valid}, 32'd1);
    check("rx_data", {22'd0, rx_data}, {22'd0, f});
    MOSI = 1'b0;
    tick();
    check("rx_valid_single", {31'd0, rx_valid}, 32'd0);
  endtask

  task automatic end_frame();
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    tick();
    check("miso_idle", {31'd0, MISO}, 32'd0);
  endtask

  // Offer tx_valid for n cycles where no transmit may start.
  task automatic tx_ignored(input int n);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check("miso_quiet", {31'd0, MISO}, 32'd0);
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_byte;
    logic [9:0] part;

    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'd0; tx_valid = 1'b0;
    tick();
    tick();
    check("rst_miso", {31'd0, MISO}, 32'd0);
    check("rst_rx_data", {22'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write address, then write data with tx_valid noise in WRITE
    send_frame(10'h0A5);
    end_frame();
    send_frame(10'h13C);
    tx_ignored(3);
    check("rx_data_hold", {22'd0, rx_data}, 32'h13C);
    end_frame();

    // Read address (flag -> 1), then read data
    send_frame(10'h2A5);
    tx_ignored(2);
    end_frame();
    send_frame(10'h300);
    tick();
    check("miso_wait", {31'd0, MISO}, 32'd0);
    exp_byte = 8'hC3;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      check("miso_c3_bit", {31'd0, MISO}, {31'd0, exp_byte[k]});
      if (k == 4) begin
        // second strobe during transmit must not disturb the byte
        tx_data  = 8'h00;
        tx_valid = 1'b1;
      end else begin
        tx_valid = 1'b0;
      end
      tick();
    end
    check("miso_after_tx", {31'd0, MISO}, 32'd0);
    tx_ignored(3);
    end_frame();

    // Flag was cleared: b9=1 goes to READ_ADD, no transmit
    send_frame(10'h2FF);
    tx_ignored(10);
    end_frame();

    // Abort after 5 bits (flag stays 1 from previous frame)
    part = 10'h155;
    SS_n = 1'b0;
    tick();
    for (int i = 9; i >= 5; i--) begin
      MOSI = part[i];
      tick();
    end
    SS_n = 1'b1;
    tick();
    check("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("abort_rx_data", {22'd0, rx_data}, 32'h2FF);
    tick();
    check("abort_rx_valid2", {31'd0, rx_valid}, 32'd0);
    check("abort_miso", {31'd0, MISO}, 32'd0);

    // Full frame after abort: READ_DATA path since flag survived
    send_frame(10'h3AA);
    exp_byte = 8'h5A;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 7; k >= 4; k--) begin
      check("miso_5a_bit", {31'd0, MISO}, {31'd0, exp_byte[k]});
      if (k > 4) tick();
    end
    // Reset during the 4th transmitted bit
    rst_n = 1'b0;
    SS_n  = 1'b1;
    tick();
    check("rst_mid_miso", {31'd0, MISO}, 32'd0);
    check("rst_mid_rx_data", {22'd0, rx_data}, 32'd0);
    check("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Flag cleared by reset: b9=1 must take the READ_ADD path
    send_frame(10'h3C3);
    tx_ignored(10);
    end_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
